io_ctrl: RTL and testbench
==========================

IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameter DBITS, default 16; data/address width.
REQ-002 Parameter DEB_CYCLES, default 50000; consecutive stable cycles needed to accept a new input level (1 ms at 50 MHz).
REQ-003 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 ADDR  in  DBITS  data-memory address from the processor datapath.
REQ-006 DIN  in  DBITS  store data.
REQ-007 WE  in  1  store strobe; qualified by an I/O address hit.
REQ-008 DOUT  out  DBITS  read data for I/O addresses; combinational from ADDR and internal registers.
REQ-009 IOSEL  out  1  high when ADDR[DBITS-1:13] is nonzero, i.e. an I/O access rather than a memory access.
REQ-010 KEY  in  4  raw push buttons, active-low, asynchronous to CLK.
REQ-011 SW  in  10  raw slide switches, asynchronous to CLK.
REQ-012 HEXVAL  out  16  value driven to the four seven-segment digits.
REQ-013 LEDR  out  10  red LEDs.
REQ-014 LEDG  out  8  green LEDs.

Function
REQ-015 Register map: FFF0 KDATA (RO), FFF2 SDATA (RO), FFF4 KSTAT (R/W1C), FFF6 SSTAT (R/W1C), FFF8 HEX (R/W), FFFA LEDR (R/W), FFFC LEDG (R/W).
REQ-016 KDATA reads {12'b0, debounced KEY[3:0]}, active-low, not inverted.
REQ-017 SDATA reads {6'b0, debounced SW[9:0]}.
REQ-018 Each raw input bit passes through a 2-flop synchronizer, then a per-bit debouncer.
REQ-019 A debouncer updates its output only after the synchronized input has differed from the output for DEB_CYCLES consecutive cycles; any intermediate return to the output level restarts the count at 0.
REQ-020 Total latency from a stable raw change to a debounced change is DEB_CYCLES+2 cycles; the counter saturates and does not wrap.
REQ-021 KSTAT[3:0] bit i is set on a debounced 1->0 transition of KEY[i] (press); the bit is sticky.
REQ-022 SSTAT[9:0] bit i is set on any debounced transition of SW[i]; the bit is sticky.
REQ-023 A write to KSTAT or SSTAT clears each bit where DIN is 1; DIN 0 bits are unchanged.
REQ-024 When a set event and a W1C clear hit the same bit in the same cycle, the set wins and the bit remains 1.
REQ-025 Writes to HEX, LEDR, and LEDG take effect on the posedge where WE=1 and ADDR matches; LEDR takes DIN[9:0] and LEDG takes DIN[7:0].
REQ-026 HEXVAL, LEDR, and LEDG are the register outputs directly, with no added delay.
REQ-027 Reads of HEX, LEDR, and LEDG return the stored value, zero-extended.
REQ-028 Writes to KDATA, SDATA, or an unmapped I/O address are ignored.
REQ-029 Reads of an unmapped address with IOSEL=1 return 16'hDEAD.
REQ-030 When IOSEL=0, DOUT is 16'hDEAD and WE has no effect.
REQ-031 Read and write of the same register in one cycle: DOUT shows the pre-write value, and the new value appears the next cycle.
REQ-032 An odd ADDR (bit 0 = 1) does not decode; it is treated as unmapped.

Reset
REQ-033 RESET asserted immediately forces: HEX=0, LEDR=0, LEDG=0, KSTAT=0, SSTAT=0, all debounce counters=0, key synchronizers and debounced keys=4'hF, switch synchronizers and debounced switches=0.
REQ-034 RESET asserted mid-debounce discards the partial count.
REQ-035 No status bit is set by the first post-reset synchronization of the switches.

Structure
REQ-036 Package io_pkg holds the address constants (IO_KDATA ... IO_LEDG), the DEAD constant, and the I/O window width.
REQ-037 Sub-module io_debounce (one bit: synchronizer plus counter, parameter DEB_CYCLES) is instantiated 14 times via generate.
REQ-038 No negedge logic and no latches are permitted.

Verification
REQ-039 DEB_CYCLES=4; KEY[1] driven low -> KDATA=16'h000D after 6 cycles, KSTAT=16'h0002.
REQ-040 KEY[0] glitches low for 3 cycles, then returns high -> KDATA stays 16'h000F and KSTAT stays 0.
REQ-041 SW=10'h3FF held stable -> SDATA=16'h03FF and SSTAT=16'h03FF; write FFF6 with 16'h0001 -> SSTAT=16'h03FE.
REQ-042 Write FFF8=16'h1234, FFFA=16'hFFFF, FFFC=16'hABCD -> HEXVAL=1234, LEDR=3FF, LEDG=CD; read-back FFFA=16'h03FF.
REQ-043 KSTAT bit 2 set and KEY[2] press debounces in the same cycle as a write FFF4=16'h0004 -> KSTAT bit 2 remains 1; read FFEE -> DEAD; read 0100 -> IOSEL=0, DOUT=DEAD.
REQ-044 RESET pulsed during a LEDR=0x155 state and mid-debounce -> all outputs 0, KDATA=000F, SSTAT=0 while inputs remain steady.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - I/O register map constants shared by the io_ctrl slice
package io_pkg;

  // Lowest address bit of the I/O window; any set bit at or above it selects I/O
  localparam int IO_WIN_LSB = 13;

  localparam logic [15:0] IO_KDATA = 16'hFFF0;
  localparam logic [15:0] IO_SDATA = 16'hFFF2;
  localparam logic [15:0] IO_KSTAT = 16'hFFF4;
  localparam logic [15:0] IO_SSTAT = 16'hFFF6;
  localparam logic [15:0] IO_HEX   = 16'hFFF8;
  localparam logic [15:0] IO_LEDR  = 16'hFFFA;
  localparam logic [15:0] IO_LEDG  = 16'hFFFC;

  // Returned for anything that is not a mapped I/O register
  localparam logic [15:0] IO_DEAD  = 16'hDEAD;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SWS  = 10;

endpackage

// File: rtl/io_ctrl_if.sv
// rtl/io_ctrl_if.sv - processor data-memory bus as seen by the I/O block
interface io_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] din;
  logic             we;
  logic [DBITS-1:0] dout;
  logic             iosel;

  modport master (output addr, output din, output we, input dout, input iosel);
  modport slave  (input addr, input din, input we, output dout, output iosel);
endinterface

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - one-bit 2-flop synchronizer followed by a stability counter
module io_debounce #(
  parameter int   DEB_CYCLES = 50000,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic change
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  // Count consecutive cycles the synchronized input disagrees with the output;
  // flip the output on the last one, restart on any agreement
  always_comb begin
    sync_d = {sync_q[0], raw};
    cnt_d  = cnt_q;
    out_d  = out_q;
    change = 1'b0;
    if (sync_q[1] == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CW'(DEB_CYCLES - 1)) begin
      out_d  = sync_q[1];
      cnt_d  = '0;
      change = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer, counter and output level registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RST_VAL}};
      cnt_q  <= '0;
      out_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign level = out_q;
endmodule

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - memory-mapped keys, switches, status, hex display and LED registers
module io_ctrl
  import io_pkg::*;
#(
  parameter int DBITS      = 16,
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  io_ctrl_if.slave    bus,
  input  logic [3:0]  key,
  input  logic [9:0]  sw,
  output logic [15:0] hexval,
  output logic [9:0]  ledr,
  output logic [7:0]  ledg
);
  localparam int NIN = NUM_KEYS + NUM_SWS;

  logic [NIN-1:0] raw, deb, chg;
  logic [15:0]    hex_q, hex_d;
  logic [9:0]     ledr_q, ledr_d;
  logic [7:0]     ledg_q, ledg_d;
  logic [3:0]     kstat_q, kstat_d;
  logic [9:0]     sstat_q, sstat_d;
  logic           iosel, wr;
  logic [15:0]    rd_data;

  function automatic logic at(input logic [DBITS-1:0] a, input logic [15:0] r);
    return a == DBITS'(r);
  endfunction

  // Keys occupy bits 3:0 and idle high; switches occupy bits 13:4 and idle low
  assign raw = {sw, key};

  for (genvar i = 0; i < NIN; i++) begin : g_deb
    io_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    ((i < NUM_KEYS) ? 1'b1 : 1'b0)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[i]),
      .level  (deb[i]),
      .change (chg[i])
    );
  end

  assign iosel     = |bus.addr[DBITS-1:IO_WIN_LSB];
  assign wr        = iosel & bus.we;
  assign bus.iosel = iosel;

  // Register writes and sticky status; a same-cycle set event beats a W1C clear
  always_comb begin
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    kstat_d = kstat_q;
    sstat_d = sstat_q;
    if (wr && at(bus.addr, IO_HEX))   hex_d   = bus.din[15:0];
    if (wr && at(bus.addr, IO_LEDR))  ledr_d  = bus.din[9:0];
    if (wr && at(bus.addr, IO_LEDG))  ledg_d  = bus.din[7:0];
    if (wr && at(bus.addr, IO_KSTAT)) kstat_d = kstat_q & ~bus.din[3:0];
    if (wr && at(bus.addr, IO_SSTAT)) sstat_d = sstat_q & ~bus.din[9:0];
    kstat_d = kstat_d | (chg[3:0] & deb[3:0]);
    sstat_d = sstat_d | chg[NIN-1:NUM_KEYS];
  end

  // Read mux; the value is the pre-write contents of the addressed register
  always_comb begin
    rd_data = IO_DEAD;
    if (iosel) begin
      if (at(bus.addr, IO_KDATA))      rd_data = {12'b0, deb[3:0]};
      else if (at(bus.addr, IO_SDATA)) rd_data = {6'b0, deb[NIN-1:NUM_KEYS]};
      else if (at(bus.addr, IO_KSTAT)) rd_data = {12'b0, kstat_q};
      else if (at(bus.addr, IO_SSTAT)) rd_data = {6'b0, sstat_q};
      else if (at(bus.addr, IO_HEX))   rd_data = hex_q;
      else if (at(bus.addr, IO_LEDR))  rd_data = {6'b0, ledr_q};
      else if (at(bus.addr, IO_LEDG))  rd_data = {8'b0, ledg_q};
    end
  end

  assign bus.dout = DBITS'(rd_data);

  // Output and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
      kstat_q <= '0;
      sstat_q <= '0;
    end else begin
      hex_q   <= hex_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      kstat_q <= kstat_d;
      sstat_q <= sstat_d;
    end
  end

  assign hexval = hex_q;
  assign ledr   = ledr_q;
  assign ledg   = ledg_q;
endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - randomized and directed bench for io_ctrl against a window-based model
module tb_io_ctrl;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [15:0] hexval;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  io_ctrl_if #(.DBITS(16)) bus();

  io_ctrl #(.DBITS(16), .DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .key    (key),
    .sw     (sw),
    .hexval (hexval),
    .ledr   (ledr),
    .ledg   (ledg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: raw samples per edge (index 0 newest) and architectural registers
  logic [13:0] hist[$];
  logic [13:0] m_lvl;
  logic [3:0]  m_kstat;
  logic [9:0]  m_sstat;
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    hist = {};
    for (int k = 0; k <= DEB; k++) hist.push_back(14'h000F);
    m_lvl   = 14'h000F;
    m_kstat = '0;
    m_sstat = '0;
    m_hex   = '0;
    m_ledr  = '0;
    m_ledg  = '0;
  endtask

  // A level is accepted once the raw samples taken 2..DEB+1 edges ago all agree on it
  task automatic m_step();
    logic [13:0] ev;
    logic        v;
    bit          same;
    ev = '0;
    for (int b = 0; b < 14; b++) begin
      v = hist[1][b];
      same = 1;
      for (int k = 1; k <= DEB; k++) if (hist[k][b] != v) same = 0;
      if (same && v != m_lvl[b]) ev[b] = 1'b1;
    end
    if (bus.we && bus.addr[15:13] != 3'b000) begin
      case (bus.addr)
        16'hFFF4: m_kstat = m_kstat & ~bus.din[3:0];
        16'hFFF6: m_sstat = m_sstat & ~bus.din[9:0];
        16'hFFF8: m_hex   = bus.din;
        16'hFFFA: m_ledr  = bus.din[9:0];
        16'hFFFC: m_ledg  = bus.din[7:0];
        default: ;
      endcase
    end
    m_kstat = m_kstat | (ev[3:0] & m_lvl[3:0]);
    m_sstat = m_sstat | ev[13:4];
    m_lvl   = m_lvl ^ ev;
    hist.push_front({sw, key});
    void'(hist.pop_back());
  endtask

  function automatic logic [15:0] m_dout(input logic [15:0] a);
    if (a[15:13] == 3'b000) return 16'hDEAD;
    case (a)
      16'hFFF0: return {12'b0, m_lvl[3:0]};
      16'hFFF2: return {6'b0, m_lvl[13:4]};
      16'hFFF4: return {12'b0, m_kstat};
      16'hFFF6: return {6'b0, m_sstat};
      16'hFFF8: return m_hex;
      16'hFFFA: return {6'b0, m_ledr};
      16'hFFFC: return {8'b0, m_ledg};
      default:  return 16'hDEAD;
    endcase
  endfunction

  initial begin : model_proc
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("dout",   bus.dout, m_dout(bus.addr));
        check("iosel",  bus.iosel, bus.addr[15:13] != 3'b000);
        check("hexval", hexval, m_hex);
        check("ledr",   ledr, m_ledr);
        check("ledg",   ledg, m_ledg);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, n_cmp %0d", n_cmp);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    bus.addr = a;
    bus.we   = 1'b0;
    @(negedge clk);
    check(nm, bus.dout, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    step();
    bus.we   = 1'b0;
  endtask

  initial begin : stim
    int idx;
    key = 4'hF; sw = '0;
    bus.addr = '0; bus.din = '0; bus.we = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_hexval", hexval, 16'h0000);
    check("rst_ledr", ledr, 10'h000);
    rd(16'hFFF0, 16'h000F, "rst_kdata");
    rd(16'hFFF6, 16'h0000, "rst_sstat");
    step();
    rst = 1'b0;
    repeat (4) step();

    // Key 1 press: debounced after DEB+2 edges, status set
    key = 4'hD;
    repeat (5) step();
    rd(16'hFFF0, 16'h000F, "kdata_before_latency");
    step();
    rd(16'hFFF0, 16'h000D, "kdata_press");
    rd(16'hFFF4, 16'h0002, "kstat_press");
    step();
    key = 4'hF;
    repeat (8) step();
    rd(16'hFFF4, 16'h0002, "kstat_release_sticky");
    wr(16'hFFF4, 16'h0002);
    rd(16'hFFF4, 16'h0000, "kstat_w1c");

    // Three-cycle glitch on key 0 is rejected
    step();
    key = 4'hE;
    repeat (3) step();
    key = 4'hF;
    repeat (8) step();
    rd(16'hFFF0, 16'h000F, "kdata_glitch");
    rd(16'hFFF4, 16'h0000, "kstat_glitch");

    // All switches on
    step();
    sw = 10'h3FF;
    repeat (8) step();
    rd(16'hFFF2, 16'h03FF, "sdata_all");
    rd(16'hFFF6, 16'h03FF, "sstat_all");
    wr(16'hFFF6, 16'h0001);
    rd(16'hFFF6, 16'h03FE, "sstat_w1c");

    // Output registers
    wr(16'hFFF8, 16'h1234);
    wr(16'hFFFA, 16'hFFFF);
    wr(16'hFFFC, 16'hABCD);
    rd(16'hFFFA, 16'h03FF, "ledr_readback");
    check("hexval_lit", hexval, 16'h1234);
    check("ledr_lit", ledr, 10'h3FF);
    check("ledg_lit", ledg, 8'hCD);
    rd(16'hFFFC, 16'h00CD, "ledg_readback");

    // Read and write of HEX in the same cycle
    step();
    bus.addr = 16'hFFF8; bus.din = 16'h5555; bus.we = 1'b1;
    @(negedge clk);
    check("hex_rd_during_wr", bus.dout, 16'h1234);
    step();
    bus.we = 1'b0;
    rd(16'hFFF8, 16'h5555, "hex_after_wr");

    // Key 2: set a status bit, then a new press lands with a W1C of that bit
    step();
    key = 4'hB;
    repeat (8) step();
    key = 4'hF;
    repeat (8) step();
    rd(16'hFFF4, 16'h0004, "kstat_k2");
    step();
    key = 4'hB;
    repeat (5) step();
    bus.addr = 16'hFFF4; bus.din = 16'h0004; bus.we = 1'b1;
    step();
    bus.we = 1'b0;
    rd(16'hFFF4, 16'h0004, "kstat_set_wins");
    wr(16'hFFF4, 16'h0004);
    rd(16'hFFF4, 16'h0000, "kstat_clear_k2");

    // Unmapped, odd and non-I/O addresses
    rd(16'hFFEE, 16'hDEAD, "unmapped_dead");
    check("iosel_io", bus.iosel, 1'b1);
    rd(16'h0100, 16'hDEAD, "mem_dead");
    check("iosel_mem", bus.iosel, 1'b0);
    rd(16'hFFF9, 16'hDEAD, "odd_dead");
    wr(16'h1FF8, 16'h0000);
    wr(16'hFFF9, 16'h0000);
    rd(16'hFFF8, 16'h5555, "hex_unchanged");

    // Reset in the middle of a key 3 debounce with LEDR holding a value
    key = 4'hF;
    repeat (8) step();
    wr(16'hFFFA, 16'h0155);
    rd(16'hFFFA, 16'h0155, "ledr_155");
    step();
    key = 4'h7;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("async_rst_ledr", ledr, 10'h000);
    check("async_rst_hexval", hexval, 16'h0000);
    check("async_rst_ledg", ledg, 8'h00);
    rd(16'hFFF0, 16'h000F, "rst_mid_kdata");
    rd(16'hFFF6, 16'h0000, "rst_mid_sstat");
    step();
    rst = 1'b0;
    repeat (5) step();
    rd(16'hFFF0, 16'h000F, "partial_count_discarded");
    step();
    rd(16'hFFF0, 16'h0007, "kdata_after_rst");

    // Randomized traffic on inputs and bus
    key = 4'hF;
    repeat (3000) begin
      step();
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        key[idx] = ~key[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 9);
        sw[idx] = ~sw[idx];
      end
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4, 5, 6: bus.addr = 16'hFFF0 + 16'($urandom_range(0, 6) * 2);
        7:  bus.addr = 16'hFFF1 + 16'($urandom_range(0, 6) * 2);
        8:  bus.addr = 16'hFFEE;
        9:  bus.addr = 16'hFFFE;
        10: bus.addr = 16'($urandom_range(0, 16'h1FFF));
        default: bus.addr = 16'($urandom);
      endcase
      bus.we  = ($urandom_range(0, 2) == 0);
      bus.din = 16'($urandom);
    end
    step();
    bus.we = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
